uart_tx_arb: RTL

//  Shares the single UART TX FIFO write port between three byte sources:
//  - rx loopback echo
//  - monitor messages (send_char path)
//  - CPU uart_io writes

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/uart_arb_fifo.sv | 53 +++++
 rtl/uart_tx_arb.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared source IDs, data width and round-robin helper for the UART TX arbiter.
package uart_arb_pkg;

    localparam int DATA_W = 8;

    localparam logic [1:0] SRC_MON  = 2'd0;
    localparam logic [1:0] SRC_IO   = 2'd1;
    localparam logic [1:0] SRC_ECHO = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    // Rotation MON -> IO -> ECHO -> MON; NONE restarts the search at MON.
    function automatic logic [1:0] next_src(input logic [1:0] last);
        case (last)
            SRC_MON: return SRC_IO;
            SRC_IO:  return SRC_ECHO;
            default: return SRC_MON;
        endcase
    endfunction

endpackage

// File: rtl/uart_arb_fifo.sv
// Small synchronous byte FIFO used to buffer loopback echo bytes.
module uart_arb_fifo
    import uart_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;
    logic              push_ok;
    logic              pop_ok;

    // A push into a full buffer is only safe when a pop frees the slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rptr];

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing the TX FIFO write port between echo, monitor and CPU bytes.
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int ECHO_DEPTH = 4,
    parameter int ECHO_AW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              echo_en,
    input  logic              echo_we,
    input  logic [DATA_W-1:0] echo_data,
    output logic              echo_ovf,
    input  logic              echo_ovf_clr,
    input  logic              mon_valid,
    input  logic [DATA_W-1:0] mon_data,
    input  logic              mon_lock,
    output logic              mon_ready,
    input  logic              io_valid,
    input  logic [DATA_W-1:0] io_data,
    output logic              io_ready,
    input  logic              tx_fifo_full,
    output logic              tx_wten,
    output logic [DATA_W-1:0] tx_wdata,
    output logic              busy
);

    logic [1:0]        rr_last;
    logic              lock_st;
    logic [1:0]        grant;
    logic [1:0]        cand;
    logic [3:0]        req;
    logic              echo_push;
    logic              echo_pop;
    logic              echo_drop;
    logic              echo_full;
    logic              echo_empty;
    logic [DATA_W-1:0] echo_dout;

    uart_arb_fifo #(
        .DEPTH (ECHO_DEPTH),
        .AW    (ECHO_AW)
    ) u_echo_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (echo_push),
        .pop   (echo_pop),
        .din   (echo_data),
        .dout  (echo_dout),
        .full  (echo_full),
        .empty (echo_empty)
    );

    assign req = {1'b0, ~echo_empty, io_valid, mon_valid};

    // Grant is forced idle during reset so every output reads 0 while rst_n is low.
    always_comb begin
        grant = SRC_NONE;
        cand  = next_src(rr_last);
        if (rst_n) begin
            if (lock_st) begin
                if (mon_valid) grant = SRC_MON;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (grant == SRC_NONE && req[cand]) grant = cand;
                    cand = next_src(cand);
                end
            end
        end
    end

    always_comb begin
        tx_wdata = '0;
        case (grant)
            SRC_MON:  tx_wdata = mon_data;
            SRC_IO:   tx_wdata = io_data;
            SRC_ECHO: tx_wdata = echo_dout;
            default:  tx_wdata = '0;
        endcase
    end

    assign tx_wten   = (grant != SRC_NONE) & ~tx_fifo_full;
    assign mon_ready = tx_wten & (grant == SRC_MON);
    assign io_ready  = tx_wten & (grant == SRC_IO);
    assign busy      = rst_n & (mon_valid | io_valid | ~echo_empty);

    assign echo_pop  = tx_wten & (grant == SRC_ECHO);
    assign echo_push = echo_we & echo_en & (~echo_full | echo_pop);
    assign echo_drop = echo_we & echo_en & echo_full & ~echo_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last  <= SRC_ECHO;
            lock_st  <= 1'b0;
            echo_ovf <= 1'b0;
        end else begin
            if (tx_wten) rr_last <= grant;
            if (mon_ready && mon_lock) lock_st <= 1'b1;
            else if (!mon_lock)        lock_st <= 1'b0;
            if (echo_ovf_clr)   echo_ovf <= 1'b0;
            else if (echo_drop) echo_ovf <= 1'b1;
        end
    end

endmodule
